// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg: shared types and constants for the serial adder/subtractor.
//   state_t  : FSM state encoding (ST_IDLE, ST_BUSY, ST_DONE)
//   max_pos  : most positive two's-complement value of a given width (0 then ones)
//   max_neg  : most negative two's-complement value of a given width (1 then zeros)
// Both helpers return 64-bit values; callers truncate to their own width.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [63:0] max_pos(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] max_neg(input int width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/serial_addsub_if.sv
// serial_addsub_if: operand and result channels of serial_addsub.
//   in_valid/in_ready : operand handshake (a, b, subtract)
//   out_valid/out_ready : result handshake (s, overflow)
// Handshake rule for both channels: a transfer happens on a rising clock edge
// where valid and ready are both high; the producer holds its payload stable
// and keeps valid high until that edge, and valid never depends on ready.
//   master : environment side (drives operands, consumes results)
//   slave  : serial_addsub side
interface serial_addsub_if #(
  parameter int WIDTH = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             subtract;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             overflow;

  modport master (
    output in_valid, a, b, subtract, out_ready,
    input  in_ready, out_valid, s, overflow
  );

  modport slave (
    input  in_valid, a, b, subtract, out_ready,
    output in_ready, out_valid, s, overflow
  );

endinterface

// File: rtl/serial_addsub_digit_adder.sv
// digit_adder: combinational DIGIT-bit ripple-carry adder.
//   x, y     : in  DIGIT-bit addends
//   cin      : in  carry in
//   sum      : out DIGIT-bit sum
//   cout     : out carry out of the top bit
//   c_msb_in : out carry into the top bit (overflow = c_msb_in ^ cout on the
//              most significant digit)
module digit_adder #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  always_comb begin
    logic c;
    c        = cin;
    sum      = '0;
    c_msb_in = 1'b0;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) c_msb_in = c;
      sum[i] = x[i] ^ y[i] ^ c;
      c      = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: multi-cycle signed adder/subtractor, DIGIT bits per clock,
// least significant digit first, with signed overflow detection.
//   clk, rst   : clock, synchronous active-high reset
//   bus        : serial_addsub_if.slave (operands in, result out)
//   dbg_state  : current FSM state
// Parameters: WIDTH (>= 2), DIGIT (divides WIDTH), STEPS = WIDTH/DIGIT.
// Build option SERIAL_ADDSUB_SATURATE_EN: clamp s to the most positive /
// most negative value on overflow (overflow is still reported).
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic           clk,
  input  logic           rst,
  serial_addsub_if.slave bus,
  output state_t         dbg_state
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, res_q, res_nx;
  logic [CW-1:0]    cnt;
  logic             carry, ovf_q, ovf_nx;
  logic             last, accept, in_ready, out_valid;
  logic [DIGIT-1:0] dsum;
  logic             dcout, dc_msb;

  digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
    .x        (a_sh[DIGIT-1:0]),
    .y        (b_sh[DIGIT-1:0]),
    .cin      (carry),
    .sum      (dsum),
    .cout     (dcout),
    .c_msb_in (dc_msb)
  );

  assign last   = (cnt == CW'(STEPS - 1));
  assign accept = bus.in_valid && in_ready;

  // New digit enters at the top; after STEPS shifts the LSD sits at bit 0.
  always_comb begin
    res_nx = (res_q >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
    ovf_nx = dc_msb ^ dcout;
`ifdef SERIAL_ADDSUB_SATURATE_EN
    // On the last step a_sh[DIGIT-1] is the sign bit of the original A.
    if (last && ovf_nx) begin
      res_nx = a_sh[DIGIT-1] ? WIDTH'(max_neg(WIDTH)) : WIDTH'(max_pos(WIDTH));
    end
`else
`endif
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = !rst;
        if (bus.in_valid && !rst) state_nx = ST_BUSY;
      end
      ST_BUSY: begin
        if (last) state_nx = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      res_q <= '0;
      carry <= 1'b0;
      ovf_q <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            // Subtraction as A + ~B + 1: invert B, seed carry with 1.
            a_sh  <= bus.a;
            b_sh  <= bus.subtract ? ~bus.b : bus.b;
            carry <= bus.subtract;
            cnt   <= '0;
          end
        end
        ST_BUSY: begin
          a_sh  <= a_sh >> DIGIT;
          b_sh  <= b_sh >> DIGIT;
          carry <= dcout;
          cnt   <= cnt + 1'b1;
          res_q <= res_nx;
          if (last) ovf_q <= ovf_nx;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.s         = res_q;
  assign bus.overflow  = ovf_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: randomized and directed bench for serial_addsub with a
// queue-based scoreboard. Two instances: WIDTH=8/DIGIT=2 and WIDTH=16/DIGIT=16.
module tb_serial_addsub;
  import serial_addsub_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  serial_addsub_if #(.WIDTH(8))  b8  ();
  serial_addsub_if #(.WIDTH(16)) b16 ();
  state_t st8, st16;

  serial_addsub #(.WIDTH(8), .DIGIT(2)) dut8 (
    .clk(clk), .rst(rst), .bus(b8), .dbg_state(st8)
  );
  serial_addsub #(.WIDTH(16), .DIGIT(16)) dut16 (
    .clk(clk), .rst(rst), .bus(b16), .dbg_state(st16)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_err    = 0;
  logic [8:0]  exp8_q[$];
  logic [16:0] exp16_q[$];
  int          acc8_q[$];
  int          acc16_q[$];
  logic rnd_rdy = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic err(input string nm);
    n_checks++;
    n_err++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Reference: exact integer result, range test, then wrap or clamp.
  function automatic logic [64:0] ref_op(input int w, input longint av, input longint bv,
                                         input logic sub);
    longint r, maxp, minn;
    logic   ovf;
    logic [63:0] mask;
    r    = sub ? av - bv : av + bv;
    maxp = (longint'(1) <<< (w - 1)) - 1;
    minn = -maxp - 1;
    ovf  = (r > maxp) || (r < minn);
`ifdef SERIAL_ADDSUB_SATURATE_EN
    if (ovf) r = (r > maxp) ? maxp : minn;
`endif
    mask = (64'd1 << w) - 64'd1;
    return {ovf, 64'(r) & mask};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send8(input logic [7:0] av, input logic [7:0] bv, input logic sub,
                       input logic keep);
    int g = 0;
    logic [64:0] e;
    @(negedge clk);
    b8.a = av; b8.b = bv; b8.subtract = sub; b8.in_valid = 1'b1;
    while (!b8.in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!b8.in_ready) err("accept8_timeout");
    else if (keep) begin
      e = ref_op(8, longint'($signed(av)), longint'($signed(bv)), sub);
      exp8_q.push_back({e[64], e[7:0]});
      acc8_q.push_back(cyc + 1);
    end
    @(negedge clk);
    b8.in_valid = 1'b0;
    b8.a = 8'($urandom); b8.b = 8'($urandom); b8.subtract = 1'($urandom);
  endtask

  task automatic send16(input logic [15:0] av, input logic [15:0] bv, input logic sub);
    int g = 0;
    logic [64:0] e;
    @(negedge clk);
    b16.a = av; b16.b = bv; b16.subtract = sub; b16.in_valid = 1'b1;
    while (!b16.in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!b16.in_ready) err("accept16_timeout");
    else begin
      e = ref_op(16, longint'($signed(av)), longint'($signed(bv)), sub);
      exp16_q.push_back({e[64], e[15:0]});
      acc16_q.push_back(cyc + 1);
    end
    @(negedge clk);
    b16.in_valid = 1'b0;
    b16.a = 16'($urandom); b16.b = 16'($urandom);
  endtask

  task automatic drain8();
    int g = 0;
    while ((exp8_q.size() != 0 || b8.out_valid) && g < 500) begin
      @(negedge clk);
      g++;
    end
    chk("drain8_left", 64'(exp8_q.size()), 64'd0);
  endtask

  task automatic drain16();
    int g = 0;
    while ((exp16_q.size() != 0 || b16.out_valid) && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("drain16_left", 64'(exp16_q.size()), 64'd0);
  endtask

  // Random consumer back-pressure, changed just after the active edge.
  always begin
    @(posedge clk);
    #1;
    if (rnd_rdy) b8.out_ready = 1'($urandom_range(0, 1));
  end

  // ---------------- monitors ----------------
  logic       pv8 = 1'b0, pv16 = 1'b0;
  logic [7:0] hs8;
  logic       ho8;

  always @(negedge clk) begin
    logic [8:0] e;
    if (rst) pv8 = 1'b0;
    else begin
      if (b8.out_valid) begin
        chk("in_ready_in_done8", 64'(b8.in_ready), 64'd0);
        if (!pv8) begin
          if (exp8_q.size() == 0) err("unexpected_valid8");
          else chk("latency8", 64'(cyc - acc8_q[0]), 64'd4);
          hs8 = b8.s;
          ho8 = b8.overflow;
        end else begin
          chk("hold_s8", 64'(b8.s), 64'(hs8));
          chk("hold_ovf8", 64'(b8.overflow), 64'(ho8));
        end
        if (b8.out_ready && exp8_q.size() != 0) begin
          e = exp8_q.pop_front();
          void'(acc8_q.pop_front());
          chk("s8", 64'(b8.s), 64'(e[7:0]));
          chk("ovf8", 64'(b8.overflow), 64'(e[8]));
        end
      end
      pv8 = b8.out_valid && !b8.out_ready;
    end
  end

  always @(negedge clk) begin
    logic [16:0] e;
    if (rst) pv16 = 1'b0;
    else begin
      if (b16.out_valid && !pv16) begin
        if (exp16_q.size() == 0) err("unexpected_valid16");
        else begin
          chk("latency16", 64'(cyc - acc16_q[0]), 64'd1);
          e = exp16_q.pop_front();
          void'(acc16_q.pop_front());
          chk("s16", 64'(b16.s), 64'(e[15:0]));
          chk("ovf16", 64'(b16.overflow), 64'(e[16]));
        end
      end
      pv16 = b16.out_valid && !b16.out_ready;
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] pat [5];
  logic [7:0] ra, rb;

  function automatic logic [7:0] pick8();
    int r = $urandom_range(0, 9);
    if (r < 5) return pat[r];
    return 8'($urandom);
  endfunction

  initial begin
    pat = '{8'h7f, 8'h80, 8'hff, 8'h00, 8'h01};
    b8.in_valid = 1'b0; b8.a = '0; b8.b = '0; b8.subtract = 1'b0; b8.out_ready = 1'b1;
    b16.in_valid = 1'b0; b16.a = '0; b16.b = '0; b16.subtract = 1'b0; b16.out_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready8", 64'(b8.in_ready), 64'd0);
    chk("rst_out_valid8", 64'(b8.out_valid), 64'd0);
    chk("rst_s8", 64'(b8.s), 64'd0);
    chk("rst_ovf8", 64'(b8.overflow), 64'd0);
    chk("rst_state8", 64'(st8), 64'(ST_IDLE));
    chk("rst_in_ready16", 64'(b16.in_ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("release_in_ready8", 64'(b8.in_ready), 64'd1);

    // Directed arithmetic cases.
    send8(8'd100, 8'd27, 1'b0, 1'b1);
    send8(8'd100, 8'd28, 1'b0, 1'b1);
    send8(8'h80, 8'd1, 1'b1, 1'b1);
    send8(8'd5, 8'd7, 1'b1, 1'b1);
    drain8();

    // Back-pressure: result held while out_ready is low.
    @(posedge clk); #1; b8.out_ready = 1'b0;
    send8(8'd60, 8'd70, 1'b0, 1'b1);
    begin
      int g = 0;
      while (!b8.out_valid && g < 20) begin
        @(negedge clk);
        g++;
      end
      if (!b8.out_valid) err("hold_wait_valid8");
    end
    repeat (10) begin
      @(negedge clk);
      b8.a = 8'($urandom); b8.b = 8'($urandom);
      chk("hold_in_ready8", 64'(b8.in_ready), 64'd0);
    end
    @(posedge clk); #1; b8.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("in_ready_after_hs8", 64'(b8.in_ready), 64'd1);

    // Reset during the second BUSY step aborts the operation.
    send8(8'd20, 8'd30, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_in_ready8", 64'(b8.in_ready), 64'd0);
    chk("abort_state8", 64'(st8), 64'(ST_IDLE));
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort_no_valid8", 64'(b8.out_valid), 64'd0);
    send8(8'hfd, 8'hfc, 1'b0, 1'b1);
    drain8();

    // Randomized traffic with boundary operands and random back-pressure.
    rnd_rdy = 1'b1;
    repeat (60) begin
      ra = pick8();
      rb = pick8();
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send8(ra, rb, 1'($urandom), 1'b1);
    end
    drain8();
    rnd_rdy = 1'b0;
    @(posedge clk); #1; b8.out_ready = 1'b1;

    // Single-step configuration.
    send16(16'h7fff, 16'h0001, 1'b0);
    send16(16'h8000, 16'h0001, 1'b1);
    send16(16'h1234, 16'h4321, 1'b1);
    repeat (10) send16(16'($urandom), 16'($urandom), 1'($urandom));
    drain16();

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
